// File: rtl/zap_fetch_fifo_pkg.sv
// rtl/zap_fetch_fifo_pkg.sv - shared payload widths, constants and entry type
// Purpose: common ZAP fetch payload definitions used by the fetch FIFO,
// its storage and its bus interface.
// Ports: none (package).
package zap_fetch_fifo_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  // Value presented on the payload outputs whenever no entry is valid.
  localparam logic [INSTR_W-1:0] ABORT_PAYLOAD = 32'd0;

  // One queued fetch result, 97 bits: {abort, pc_plus_8, pc, instruction}.
  typedef struct packed {
    logic            abort;
    logic [PC_W-1:0] pc_plus_8;
    logic [PC_W-1:0] pc;
    logic [INSTR_W-1:0] instruction;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/zap_fetch_fifo_if.sv
// rtl/zap_fetch_fifo_if.sv - fetch/decode handshake bundle for the fetch FIFO
// Purpose: groups the fetch-side payload, downstream stall and decode-side
// outputs of zap_fetch_fifo.
// Ports (signals):
//   i_valid, i_instruction, i_instr_abort, i_pc_ff, i_pc_plus_8_ff - fetch payload
//   i_stall                                                        - downstream hold
//   o_full                                                         - back-pressure to fetch
//   o_valid, o_instruction, o_instr_abort, o_pc_ff, o_pc_plus_8_ff - head entry
//   o_count                                                        - occupancy
// Modports: master = user of the FIFO (fetch + decode side), slave = the FIFO.
interface zap_fetch_fifo_if #(
  parameter int DEPTH = 4
);
  import zap_fetch_fifo_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic               i_valid;
  logic [INSTR_W-1:0] i_instruction;
  logic               i_instr_abort;
  logic [PC_W-1:0]    i_pc_ff;
  logic [PC_W-1:0]    i_pc_plus_8_ff;
  logic               i_stall;

  logic               o_full;
  logic               o_valid;
  logic [INSTR_W-1:0] o_instruction;
  logic               o_instr_abort;
  logic [PC_W-1:0]    o_pc_ff;
  logic [PC_W-1:0]    o_pc_plus_8_ff;
  logic [CW-1:0]      o_count;

  modport master (
    output i_valid, i_instruction, i_instr_abort, i_pc_ff, i_pc_plus_8_ff, i_stall,
    input  o_full, o_valid, o_instruction, o_instr_abort, o_pc_ff, o_pc_plus_8_ff, o_count
  );

  modport slave (
    input  i_valid, i_instruction, i_instr_abort, i_pc_ff, i_pc_plus_8_ff, i_stall,
    output o_full, o_valid, o_instruction, o_instr_abort, o_pc_ff, o_pc_plus_8_ff, o_count
  );

endinterface

// File: rtl/zap_fetch_fifo_mem.sv
// rtl/zap_fetch_fifo_mem.sv - DEPTH x 97 register file for the fetch FIFO
// Purpose: entry storage with one synchronous write port and one
// asynchronous read port; contents are not reset.
// Ports:
//   clk   - clock
//   we    - write enable, writes wdata to waddr on the rising edge
//   waddr - write address
//   wdata - entry to store
//   raddr - read address
//   rdata - entry at raddr (combinational)
module zap_fetch_fifo_mem
  import zap_fetch_fifo_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  fetch_entry_t wdata,
  input  logic [AW-1:0] raddr,
  output fetch_entry_t rdata
);

  fetch_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/zap_fetch_fifo.sv
// rtl/zap_fetch_fifo.sv - first-word-fall-through FIFO between fetch and decode
// Purpose: buffers fetched instructions, stops accepting after an aborted
// fetch until flushed, and presents the head entry to decode.
// Ports:
//   i_clk     - clock, all state changes on its rising edge
//   i_reset_n - asynchronous active-low reset
//   i_clear   - flush request, overrides push and pop
//   bus       - zap_fetch_fifo_if slave: fetch payload, stall, head outputs, count
module zap_fetch_fifo
  import zap_fetch_fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_clear,
  zap_fetch_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          sleep;

  logic          full;
  logic          valid;
  logic          push;
  logic          pop;

  fetch_entry_t  wr_entry;
  fetch_entry_t  head;

  // Full and valid come only from registered count so fetch never sees a
  // combinational loop through stall or its own valid.
  assign full  = (count == CW'(DEPTH));
  assign valid = (count != '0);

  // sleep blocks pushes after an aborted fetch; the queue still drains.
  assign push = bus.i_valid & ~full & ~i_clear & ~sleep;
  assign pop  = valid & ~bus.i_stall & ~i_clear;

  assign wr_entry = '{
    abort:       bus.i_instr_abort,
    pc_plus_8:   bus.i_pc_plus_8_ff,
    pc:          bus.i_pc_ff,
    instruction: bus.i_instruction
  };

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      sleep  <= 1'b0;
    end else if (i_clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      sleep  <= 1'b0;
    end else begin
      // Pointers are log2(DEPTH) wide, so increments wrap modulo DEPTH.
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (bus.i_instr_abort) begin
          sleep <= 1'b1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  zap_fetch_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (i_clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Storage is unreset, so the payload is gated by valid to keep idle
  // outputs at a known value.
  assign bus.o_full         = full;
  assign bus.o_valid        = valid;
  assign bus.o_count        = count;
  assign bus.o_instruction  = valid ? head.instruction : ABORT_PAYLOAD;
  assign bus.o_pc_ff        = valid ? head.pc        : ABORT_PAYLOAD;
  assign bus.o_pc_plus_8_ff = valid ? head.pc_plus_8 : ABORT_PAYLOAD;
  assign bus.o_instr_abort  = valid & head.abort;

endmodule
